// File: rtl/mm_arbiter.sv
// Round-robin arbiter for the shared matrix memory.
// A requester keeps the grant for a whole transaction, until it drops its
// request. A hold watchdog revokes any grant that lasts max_hold_p cycles.
// Once the watchdog fires, timeout_o stays set until the next reset.
//
// state | meaning
// eIDLE | no owner; arbitrate among pending requests
// eBUSY | owner_r holds the memory
module mm_arbiter #(
  parameter int width_p    = 16,
  parameter int height_p   = 32,
  parameter int num_req_p  = 3,
  parameter int max_hold_p = 64,
  localparam int aw = $clog2(height_p),
  localparam int iw = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cw = $clog2(max_hold_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_i,
  output logic [num_req_p-1:0]           gnt_o,
  input  logic [num_req_p*aw-1:0]        rd_addr_i,
  input  logic [num_req_p*aw-1:0]        wr_addr_i,
  input  logic [num_req_p*width_p-1:0]   wr_data_i,
  input  logic [num_req_p-1:0]           wr_v_i,
  output logic [width_p-1:0]             rd_data_o,
  output logic [aw-1:0]                  mm_read_addr_o,
  input  logic [width_p-1:0]             mm_read_data_i,
  output logic [aw-1:0]                  mm_write_addr_o,
  output logic [width_p-1:0]             mm_write_data_o,
  output logic                           mm_write_v_o,
  output logic                           timeout_o
);

  typedef enum logic {eIDLE, eBUSY} state_e;

  state_e          state_r, state_n;
  logic [iw-1:0]   owner_r, owner_n;
  logic [iw-1:0]   last_r, last_n;
  logic [cw-1:0]   hold_cnt_r, hold_cnt_n;
  logic            timeout_r, timeout_n;
  logic [iw-1:0]   winner;
  logic            owner_req;
  logic            active;

  assign owner_req = req_i[owner_r];
  // Reset low also blocks the mux, so a write cannot land on the reset edge.
  assign active    = (state_r == eBUSY) && owner_req && reset_i;

  // Round-robin pick: the first set request after last_r, with wrap-around.
  // The loop runs from the farthest candidate to the nearest, so the nearest
  // set request is written last and wins.
  always_comb begin
    logic [iw-1:0] cand;
    cand   = '0;
    winner = last_r;
    for (int k = num_req_p; k >= 1; k--) begin
      cand = iw'((int'(last_r) + k) % num_req_p);
      if (req_i[cand]) winner = cand;
    end
  end

  // State register; the synchronous reset gives requester 0 first priority.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r    <= eIDLE;
      owner_r    <= '0;
      last_r     <= iw'(num_req_p - 1);
      hold_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      owner_r    <= owner_n;
      last_r     <= last_n;
      hold_cnt_r <= hold_cnt_n;
      timeout_r  <= timeout_n;
    end
  end

  // Next state: grant, release, or revoke by the watchdog.
  always_comb begin
    state_n    = state_r;
    owner_n    = owner_r;
    last_n     = last_r;
    hold_cnt_n = hold_cnt_r;
    timeout_n  = timeout_r;
    case (state_r)
      eIDLE: begin
        if (|req_i) begin
          state_n    = eBUSY;
          owner_n    = winner;
          last_n     = winner;
          hold_cnt_n = cw'(1);
        end
      end
      eBUSY: begin
        if (!owner_req) begin
          state_n = eIDLE;
        end else if (hold_cnt_r == cw'(max_hold_p)) begin
          state_n   = eIDLE;
          timeout_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt_r + 1'b1;
        end
      end
      default: state_n = eIDLE;
    endcase
  end

  // Grant and memory mux. Only the owner's slices are ever forwarded.
  always_comb begin
    gnt_o           = '0;
    mm_read_addr_o  = '0;
    mm_write_addr_o = '0;
    mm_write_data_o = '0;
    mm_write_v_o    = 1'b0;
    if (state_r == eBUSY) gnt_o[owner_r] = 1'b1;
    if (active) begin
      mm_read_addr_o  = rd_addr_i[int'(owner_r)*aw +: aw];
      mm_write_addr_o = wr_addr_i[int'(owner_r)*aw +: aw];
      mm_write_data_o = wr_data_i[int'(owner_r)*width_p +: width_p];
      mm_write_v_o    = wr_v_i[owner_r];
    end
  end

  assign rd_data_o = mm_read_data_i;
  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_mm_arbiter.sv
// Scoreboard bench for mm_arbiter: stimulus pushes the expected outputs for
// each cycle, and a negedge monitor pops and compares them.
module tb_mm_arbiter;
  localparam int W  = 16;
  localparam int H  = 32;
  localparam int N  = 3;
  localparam int MH = 4;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset_i = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N-1:0]    wr_v_i = '0;
  logic [N-1:0]    gnt_o;
  logic [N*AW-1:0] rd_addr_i;
  logic [N*AW-1:0] wr_addr_i;
  logic [N*W-1:0]  wr_data_i;
  logic [W-1:0]    rd_data_o;
  logic [AW-1:0]   mm_read_addr_o;
  logic [W-1:0]    mm_read_data_i;
  logic [AW-1:0]   mm_write_addr_o;
  logic [W-1:0]    mm_write_data_o;
  logic            mm_write_v_o;
  logic            timeout_o;

  logic [AW-1:0] ra_t [N] = '{5'd1, 5'd2, 5'd3};
  logic [AW-1:0] wa_t [N] = '{5'd5, 5'd9, 5'd7};
  logic [W-1:0]  wd_t [N] = '{16'hFFFF, 16'h1234, 16'hBEEF};

  assign rd_addr_i      = {ra_t[2], ra_t[1], ra_t[0]};
  assign wr_addr_i      = {wa_t[2], wa_t[1], wa_t[0]};
  assign wr_data_i      = {wd_t[2], wd_t[1], wd_t[0]};
  assign mm_read_data_i = 16'hA500 | W'(mm_read_addr_o);

  mm_arbiter #(.width_p(W), .height_p(H), .num_req_p(N), .max_hold_p(MH)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .gnt_o(gnt_o),
    .rd_addr_i(rd_addr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_v_i(wr_v_i), .rd_data_o(rd_data_o), .mm_read_addr_o(mm_read_addr_o),
    .mm_read_data_i(mm_read_data_i), .mm_write_addr_o(mm_write_addr_o),
    .mm_write_data_o(mm_write_data_o), .mm_write_v_o(mm_write_v_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          wv;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr;
    logic          tmo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare the DUT outputs with the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("gnt",        32'(gnt_o),           32'(e.gnt));
      chk("write_v",    32'(mm_write_v_o),    32'(e.wv));
      chk("write_addr", 32'(mm_write_addr_o), 32'(e.waddr));
      chk("write_data", 32'(mm_write_data_o), 32'(e.wdata));
      chk("read_addr",  32'(mm_read_addr_o),  32'(e.raddr));
      chk("rd_data",    32'(rd_data_o),       32'(16'hA500 | W'(e.raddr)));
      chk("timeout",    32'(timeout_o),       32'(e.tmo));
    end
  end

  // One cycle of stimulus. act is the owner whose accesses must reach memory
  // this cycle, or -1 when the memory mux must be idle.
  task automatic step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] wv,
                      input logic [N-1:0] eg, input int act, input logic et);
    exp_t e;
    reset_i = rst;
    req_i   = req;
    wr_v_i  = wv;
    e.gnt   = eg;
    e.tmo   = et;
    if (act >= 0) begin
      e.wv    = wv[act[1:0]];
      e.waddr = wa_t[act[1:0]];
      e.wdata = wd_t[act[1:0]];
      e.raddr = ra_t[act[1:0]];
    end else begin
      e.wv    = 1'b0;
      e.waddr = '0;
      e.wdata = '0;
      e.raddr = '0;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    step(0, 3'b000, 3'b000, 3'b000, -1, 0);

    // Single requester: grant one cycle after the request, write forwarded.
    step(1, 3'b001, 3'b001, 3'b000, -1, 0);
    step(1, 3'b001, 3'b001, 3'b001,  0, 0);
    step(1, 3'b000, 3'b001, 3'b001, -1, 0);
    step(1, 3'b000, 3'b000, 3'b000, -1, 0);

    // All requesting with all strobes high: round-robin 1,2,0 after owner 0.
    step(1, 3'b111, 3'b111, 3'b000, -1, 0);
    for (int i = 0; i < 3; i++) step(1, 3'b111, 3'b111, 3'b010, 1, 0);
    step(1, 3'b101, 3'b111, 3'b010, -1, 0);
    step(1, 3'b111, 3'b111, 3'b000, -1, 0);
    for (int i = 0; i < 3; i++) step(1, 3'b111, 3'b111, 3'b100, 2, 0);
    step(1, 3'b011, 3'b111, 3'b100, -1, 0);
    step(1, 3'b111, 3'b111, 3'b000, -1, 0);
    for (int i = 0; i < 3; i++) step(1, 3'b111, 3'b111, 3'b001, 0, 0);
    step(1, 3'b110, 3'b111, 3'b001, -1, 0);
    step(1, 3'b110, 3'b111, 3'b000, -1, 0);

    // Owner 1 holds the grant; requester 2's strobe to address 7 must not write.
    step(1, 3'b110, 3'b100, 3'b010,  1, 0);
    step(1, 3'b110, 3'b110, 3'b010,  1, 0);
    step(1, 3'b100, 3'b100, 3'b010, -1, 0);
    step(1, 3'b000, 3'b000, 3'b000, -1, 0);

    // Watchdog: owner 0 never releases; revoked after MH cycles, then 1 wins.
    step(1, 3'b011, 3'b011, 3'b000, -1, 0);
    for (int i = 0; i < MH; i++) step(1, 3'b011, 3'b011, 3'b001, 0, 0);
    step(1, 3'b011, 3'b011, 3'b000, -1, 1);
    step(1, 3'b011, 3'b011, 3'b010,  1, 1);
    step(1, 3'b000, 3'b011, 3'b010, -1, 1);
    step(1, 3'b000, 3'b000, 3'b000, -1, 1);

    // Reset mid-grant with a strobe high: grant dropped, flag cleared.
    step(1, 3'b001, 3'b001, 3'b000, -1, 1);
    step(1, 3'b001, 3'b001, 3'b001,  0, 1);
    step(0, 3'b001, 3'b001, 3'b001, -1, 1);
    step(1, 3'b110, 3'b000, 3'b000, -1, 0);
    step(1, 3'b110, 3'b000, 3'b010,  1, 0);
    step(1, 3'b000, 3'b000, 3'b010, -1, 0);
    step(1, 3'b000, 3'b000, 3'b000, -1, 0);

    repeat (2) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
